// File: rtl/reg_file_onehot_wr_if.sv
// ----------------------------------------------------------------------------
// reg_file_onehot_wr_if
// Bus bundle between the write-select decoder / ALU operand stage and the
// RISC16 register file.
//   wr_sel     one-hot write select (bit i = register i)
//   wr_data    write data
//   rd_addr_a  read port A address
//   rd_addr_b  read port B address
//   rd_data_a  read port A data (registered)
//   rd_data_b  read port B data (registered)
//   clr_req    start the clear sequence
//   clr_busy   clear sequence in progress
//   sel_err    sticky malformed-select flag
//   err_clr    clear sel_err
// master: drives writes, reads and control (decoder/datapath side)
// slave : the register file
// ----------------------------------------------------------------------------
interface reg_file_onehot_wr_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              clr_req;
    logic              clr_busy;
    logic              sel_err;
    logic              err_clr;

    modport master (
        output wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req, err_clr,
        input  rd_data_a, rd_data_b, clr_busy, sel_err
    );

    modport slave (
        input  wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req, err_clr,
        output rd_data_a, rd_data_b, clr_busy, sel_err
    );
endinterface

// File: rtl/reg_file_onehot_wr.sv
// ----------------------------------------------------------------------------
// reg_file_onehot_wr
// 8 x DATA_W register file for the RISC16 datapath. Write enables come
// straight from a 3-to-8 decoder as a one-hot select. Two registered read
// ports, a sequenced clear engine and a sticky malformed-select flag.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      reg_file_onehot_wr_if.slave (write, read, clear and error signals)
//
// Parameters:
//   DATA_W   register/data width
//   R0_ZERO  1: register 0 is hardwired to zero and writes to it are dropped
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - a legal write to register i in the same cycle as a read of
//               register i forwards wr_data to the read port (not for a
//               hardwired r0, not during a clear)
//   undefined - reads return the pre-write contents
// ----------------------------------------------------------------------------
module reg_file_onehot_wr #(
    parameter int DATA_W  = 16,
    parameter int R0_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    reg_file_onehot_wr_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] regs [8];
    logic [7:0]        wr_en;
    logic              sel_nz, sel_onehot, sel_multi;
    logic [DATA_W-1:0] rd_a_nxt, rd_b_nxt;

    // A value is one-hot when it is non-zero and clearing its lowest set bit
    // leaves nothing behind.
    assign sel_nz     = |bus.wr_sel;
    assign sel_onehot = sel_nz && ((bus.wr_sel & (bus.wr_sel - 8'd1)) == 8'd0);
    assign sel_multi  = sel_nz && !sel_onehot;

    // Per-register write enables: only in IDLE, only for a clean select, and
    // never for a hardwired r0.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < 8; i++) begin
            wr_en[i] = (state == IDLE) && sel_onehot && bus.wr_sel[i] &&
                       !((R0_ZERO != 0) && (i == 0));
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer: IDLE -> CLEAR (8 cycles, cnt 0..7) -> IDLE.
    // cnt + 1 on the last CLEAR cycle wraps 7 -> 0 as the FSM leaves.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 3'd0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign bus.clr_busy = (state == CLEAR);

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is reset explicitly because downstream logic
            // relies on all-zero contents after reset; this keeps it in
            // flops rather than a RAM macro, which is fine at 8 entries.
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if ((state == CLEAR) && (cnt == 3'(i))) begin
                    regs[i] <= '0;
                end else if (wr_en[i]) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: one-cycle registered reads with optional forwarding.
    // wr_en already excludes CLEAR and a hardwired r0.
    // ------------------------------------------------------------------
    always_comb begin
        rd_a_nxt = regs[bus.rd_addr_a];
        rd_b_nxt = regs[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en[bus.rd_addr_a]) begin
            rd_a_nxt = bus.wr_data;
        end
        if (wr_en[bus.rd_addr_b]) begin
            rd_b_nxt = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
        end else begin
            bus.rd_data_a <= rd_a_nxt;
            bus.rd_data_b <= rd_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky select error; a new bad select wins over err_clr.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sel_err <= 1'b0;
        end else if (sel_multi) begin
            bus.sel_err <= 1'b1;
        end else if (bus.err_clr) begin
            bus.sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_onehot_wr.sv
// ----------------------------------------------------------------------------
// tb_reg_file_onehot_wr
// Two instances share all stimulus: dut1 with R0_ZERO = 1, dut0 with
// R0_ZERO = 0. A behavioural model predicts every cycle's outputs; the
// prediction is queued when stimulus is applied and compared by a monitor
// one clock edge later. Scenario tasks add direct checks against fixed
// values.
// ----------------------------------------------------------------------------
module tb_reg_file_onehot_wr;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic [1:0][DATA_W-1:0] a;
        logic [1:0][DATA_W-1:0] b;
        logic                   busy;
        logic                   err;
    } sb_t;

    logic clk;
    logic reset_n;

    logic [7:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic              clr_req;
    logic              err_clr;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 -> R0_ZERO = 0 instance, 1 -> R0_ZERO = 1 instance.
    logic [DATA_W-1:0] m_regs [2][8];
    logic              m_busy;
    logic [2:0]        m_cnt;
    logic              m_err;

    sb_t sb_q [$];

    reg_file_onehot_wr_if #(.DATA_W(DATA_W)) bus0 ();
    reg_file_onehot_wr_if #(.DATA_W(DATA_W)) bus1 ();

    assign bus0.wr_sel    = wr_sel;
    assign bus0.wr_data   = wr_data;
    assign bus0.rd_addr_a = rd_addr_a;
    assign bus0.rd_addr_b = rd_addr_b;
    assign bus0.clr_req   = clr_req;
    assign bus0.err_clr   = err_clr;
    assign bus1.wr_sel    = wr_sel;
    assign bus1.wr_data   = wr_data;
    assign bus1.rd_addr_a = rd_addr_a;
    assign bus1.rd_addr_b = rd_addr_b;
    assign bus1.clr_req   = clr_req;
    assign bus1.err_clr   = err_clr;

    reg_file_onehot_wr #(.DATA_W(DATA_W), .R0_ZERO(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    reg_file_onehot_wr #(.DATA_W(DATA_W), .R0_ZERO(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                m_regs[k][i] = '0;
        m_busy = 1'b0;
        m_cnt  = 3'd0;
        m_err  = 1'b0;
        sb_q.delete();
    endtask

    // Predict the outputs after the next rising edge from the current inputs
    // and model state, queue them, then advance one clock.
    task automatic tick();
        sb_t  e;
        logic oh, multi, fwd;
        oh    = (wr_sel != 8'd0) && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
        multi = (wr_sel != 8'd0) && !oh;
        for (int k = 0; k < 2; k++) begin
            e.a[k] = m_regs[k][rd_addr_a];
            e.b[k] = m_regs[k][rd_addr_b];
`ifdef REGFILE_BYPASS_EN
            fwd = !m_busy && oh && wr_sel[rd_addr_a] && !(k == 1 && rd_addr_a == 3'd0);
            if (fwd) e.a[k] = wr_data;
            fwd = !m_busy && oh && wr_sel[rd_addr_b] && !(k == 1 && rd_addr_b == 3'd0);
            if (fwd) e.b[k] = wr_data;
`else
            fwd = 1'b0;
`endif
        end
        for (int k = 0; k < 2; k++) begin
            if (m_busy) begin
                m_regs[k][m_cnt] = '0;
            end else if (oh) begin
                for (int i = 0; i < 8; i++)
                    if (wr_sel[i] && !(k == 1 && i == 0)) m_regs[k][i] = wr_data;
            end
        end
        if (m_busy) begin
            if (m_cnt == 3'd7) m_busy = 1'b0;
            m_cnt = m_cnt + 3'd1;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_cnt  = 3'd0;
        end
        if (multi)        m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        e.busy = m_busy;
        e.err  = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: compares one queued prediction per edge, #1 after it.
    always begin
        sb_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks += 6;
            if (bus0.rd_data_a !== e.a[0]) begin errors++;
                $display("FAIL sb_rd_a_r0free t=%0t got %h exp %h", $time, bus0.rd_data_a, e.a[0]); end
            if (bus0.rd_data_b !== e.b[0]) begin errors++;
                $display("FAIL sb_rd_b_r0free t=%0t got %h exp %h", $time, bus0.rd_data_b, e.b[0]); end
            if (bus1.rd_data_a !== e.a[1]) begin errors++;
                $display("FAIL sb_rd_a_r0zero t=%0t got %h exp %h", $time, bus1.rd_data_a, e.a[1]); end
            if (bus1.rd_data_b !== e.b[1]) begin errors++;
                $display("FAIL sb_rd_b_r0zero t=%0t got %h exp %h", $time, bus1.rd_data_b, e.b[1]); end
            if (bus0.clr_busy !== e.busy || bus1.clr_busy !== e.busy) begin errors++;
                $display("FAIL sb_clr_busy t=%0t got %b/%b exp %b", $time, bus0.clr_busy, bus1.clr_busy, e.busy); end
            if (bus0.sel_err !== e.err || bus1.sel_err !== e.err) begin errors++;
                $display("FAIL sb_sel_err t=%0t got %b/%b exp %b", $time, bus0.sel_err, bus1.sel_err, e.err); end
        end
    end

    task automatic idle_inputs();
        wr_sel    = 8'd0;
        wr_data   = '0;
        clr_req   = 1'b0;
        err_clr   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        reset_n   = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({bus0.rd_data_a, bus0.rd_data_b, bus1.rd_data_a, bus1.rd_data_b} !== '0 ||
            bus0.clr_busy !== 1'b0 || bus0.sel_err !== 1'b0 ||
            bus1.clr_busy !== 1'b0 || bus1.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h/%h busy=%b err=%b exp 0",
                     bus0.rd_data_a, bus1.rd_data_a, bus0.clr_busy, bus0.sel_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            tick();
            checks++;
            if (bus0.rd_data_a !== 16'h0 || bus0.rd_data_b !== 16'h0 ||
                bus1.rd_data_a !== 16'h0 || bus1.rd_data_b !== 16'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got %h %h exp 0000", i, bus0.rd_data_a, bus0.rd_data_b);
            end
        end
    endtask

    task automatic test_write_read();
        wr_sel  = 8'h08;
        wr_data = 16'hBEEF;
        tick();
        wr_sel    = 8'h00;
        rd_addr_a = 3'd3;
        tick();
        checks++;
        if (bus0.rd_data_a !== 16'hBEEF || bus1.rd_data_a !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read_r3 got %h/%h exp beef", bus0.rd_data_a, bus1.rd_data_a);
        end
    endtask

    task automatic test_r0_zero();
        wr_sel  = 8'h01;
        wr_data = 16'h1234;
        tick();
        wr_sel    = 8'h00;
        rd_addr_b = 3'd0;
        tick();
        checks++;
        if (bus1.rd_data_b !== 16'h0000) begin
            errors++;
            $display("FAIL r0_hardwired got %h exp 0000", bus1.rd_data_b);
        end
        checks++;
        if (bus0.rd_data_b !== 16'h1234) begin
            errors++;
            $display("FAIL r0_writable got %h exp 1234", bus0.rd_data_b);
        end
    endtask

    task automatic test_sel_err();
        wr_sel = 8'h04; wr_data = 16'h1111; tick();
        wr_sel = 8'h08; wr_data = 16'h2222; tick();
        wr_sel = 8'h0C; wr_data = 16'hFFFF; tick();
        checks++;
        if (bus0.sel_err !== 1'b1 || bus1.sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set got %b/%b exp 1", bus0.sel_err, bus1.sel_err);
        end
        wr_sel = 8'h00; rd_addr_a = 3'd2; rd_addr_b = 3'd3; tick();
        checks++;
        if (bus0.rd_data_a !== 16'h1111 || bus0.rd_data_b !== 16'h2222) begin
            errors++;
            $display("FAIL bad_sel_no_write got %h %h exp 1111 2222", bus0.rd_data_a, bus0.rd_data_b);
        end
        err_clr = 1'b1; tick();
        checks++;
        if (bus0.sel_err !== 1'b0 || bus1.sel_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_clear got %b/%b exp 0", bus0.sel_err, bus1.sel_err);
        end
        wr_sel = 8'h0C; tick();
        checks++;
        if (bus0.sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_priority got %b exp 1", bus0.sel_err);
        end
        wr_sel = 8'h00; tick();
        err_clr = 1'b0; tick();
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++) begin
            wr_sel  = 8'b1 << i;
            wr_data = 16'h1000 + 16'(i * 16'h0111);
            tick();
        end
        wr_sel = 8'h00;
    endtask

    task automatic test_clear();
        int n;
        load_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        // Keep driving a write to reg 5 throughout the clear: it must be dropped.
        wr_sel  = 8'h20;
        wr_data = 16'hDEAD;
        n = (bus0.clr_busy === 1'b1) ? 1 : 0;
        for (int c = 0; c < 20 && n > 0; c++) begin
            tick();
            if (bus0.clr_busy === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL clr_busy_len got %0d cycles exp 8", n);
        end
        wr_sel = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            tick();
            checks++;
            if (bus0.rd_data_a !== 16'h0) begin
                errors++;
                $display("FAIL clear_reg%0d got %h exp 0000", i, bus0.rd_data_a);
            end
        end
    endtask

    task automatic test_clear_reset_abort();
        load_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus0.clr_busy !== 1'b0 || bus1.clr_busy !== 1'b0 ||
            bus0.rd_data_a !== 16'h0 || bus0.rd_data_b !== 16'h0) begin
            errors++;
            $display("FAIL clear_abort busy=%b rd=%h %h exp 0", bus0.clr_busy, bus0.rd_data_a, bus0.rd_data_b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i);
            tick();
            checks++;
            if (bus0.rd_data_a !== 16'h0 || bus0.clr_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_reg%0d got %h busy %b exp 0000 0", i, bus0.rd_data_a, bus0.clr_busy);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_first;
        wr_sel = 8'h20; wr_data = 16'h5555; tick();
        wr_sel = 8'h20; wr_data = 16'hA5A5; rd_addr_a = 3'd5; tick();
`ifdef REGFILE_BYPASS_EN
        exp_first = 16'hA5A5;
`else
        exp_first = 16'h5555;
`endif
        checks++;
        if (bus0.rd_data_a !== exp_first) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h exp %h", bus0.rd_data_a, exp_first);
        end
        wr_sel = 8'h00; tick();
        checks++;
        if (bus0.rd_data_a !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_next_cycle got %h exp a5a5", bus0.rd_data_a);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(9))
                0:       wr_sel = 8'h00;
                1:       wr_sel = 8'($urandom);
                default: wr_sel = 8'b1 << $urandom_range(7);
            endcase
            wr_data   = 16'($urandom);
            rd_addr_a = 3'($urandom_range(7));
            rd_addr_b = 3'($urandom_range(7));
            clr_req   = ($urandom_range(49) == 0);
            err_clr   = ($urandom_range(7) == 0);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0_zero();
        test_sel_err();
        test_clear();
        test_clear_reset_abort();
        test_bypass();
        test_back_to_back();
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
